// File: rtl/parallel_load_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : parallel_load_serializer
//  Description : Parallel-in, serial-out shifter with valid/ready load side,
//                per-word LSB/MSB-first order and consumer stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module parallel_load_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             load_ready,
    output logic             SO,
    output logic             so_valid,
    output logic             so_last,
    output logic [WIDTH-1:0] SR
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;

    logic w_last;
    logic w_accept;

    assign w_last     = (state_q == SHIFT) && (cnt_q == c_LAST_CNT);
    assign load_ready = (state_q == IDLE) | (w_last & shift_en);
    assign w_accept   = load_valid & load_ready;

    assign SO       = mode_q ? sr_q[0] : sr_q[WIDTH-1];
    assign so_valid = (state_q == SHIFT);
    assign so_last  = w_last;
    assign SR       = sr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        // A load on the last-bit edge takes priority over the shift, which
        // is what lets consecutive words stream with no idle gap.
        if (w_accept) begin
            state_d = SHIFT;
            sr_d    = load_data;
            cnt_d   = '0;
            mode_d  = mode;
        end else if ((state_q == SHIFT) && shift_en) begin
            sr_d  = mode_q ? {1'b0, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (w_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel_load_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parallel_load_serializer
//  Description : Directed self-checking bench for parallel_load_serializer
//                (WIDTH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parallel_load_serializer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             mode;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             load_ready;
    logic             SO;
    logic             so_valid;
    logic             so_last;
    logic [WIDTH-1:0] SR;

    int checks;
    int passes;

    parallel_load_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .load_valid (load_valid),
        .load_data  (load_data),
        .shift_en   (shift_en),
        .load_ready (load_ready),
        .SO         (SO),
        .so_valid   (so_valid),
        .so_last    (so_last),
        .SR         (SR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; mode = 1'b0; load_valid = 1'b0; load_data = '0; shift_en = 1'b0;
        @(negedge clk);
        checks++; if (SO !== 1'b0) $display("FAIL reset_so: got %b expected 0", SO); else passes++;
        checks++; if (so_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", so_valid); else passes++;
        checks++; if (so_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", so_last); else passes++;
        checks++; if (load_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", load_ready); else passes++;
        checks++; if (SR !== 4'b0000) $display("FAIL reset_sr: got %b expected 0000", SR); else passes++;
        rst = 1'b1;
    endtask

    task automatic test_msb_first();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        load_valid = 1'b1; load_data = 4'b1011; mode = 1'b0; shift_en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (SO !== exp_bits[3-i]) $display("FAIL msb_so[%0d]: got %b expected %b", i, SO, exp_bits[3-i]); else passes++;
            checks++; if (so_valid !== 1'b1) $display("FAIL msb_valid[%0d]: got %b expected 1", i, so_valid); else passes++;
            checks++; if (so_last !== (i == 3)) $display("FAIL msb_last[%0d]: got %b expected %b", i, so_last, (i == 3)); else passes++;
            @(negedge clk);
        end
        checks++; if (so_valid !== 1'b0) $display("FAIL msb_valid_after: got %b expected 0", so_valid); else passes++;
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp_bits;
        exp_bits = 4'b1101;
        load_valid = 1'b1; load_data = 4'b1011; mode = 1'b1; shift_en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (SO !== exp_bits[3-i]) $display("FAIL lsb_so[%0d]: got %b expected %b", i, SO, exp_bits[3-i]); else passes++;
            checks++; if (so_last !== (i == 3)) $display("FAIL lsb_last[%0d]: got %b expected %b", i, so_last, (i == 3)); else passes++;
            @(negedge clk);
        end
        checks++; if (SR !== 4'b0000) $display("FAIL lsb_sr_after: got %b expected 0000", SR); else passes++;
        checks++; if (so_valid !== 1'b0) $display("FAIL lsb_valid_after: got %b expected 0", so_valid); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits;
        exp_bits = 8'b1100_0110;
        load_valid = 1'b1; load_data = 4'b1100; mode = 1'b0; shift_en = 1'b1;
        @(negedge clk);
        load_data = 4'b0110; mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (SO !== exp_bits[7-i]) $display("FAIL b2b_so[%0d]: got %b expected %b", i, SO, exp_bits[7-i]); else passes++;
            checks++; if (so_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b expected 1", i, so_valid); else passes++;
            checks++; if (so_last !== (i == 3 || i == 7)) $display("FAIL b2b_last[%0d]: got %b expected %b", i, so_last, (i == 3 || i == 7)); else passes++;
            if (i == 4) load_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (so_valid !== 1'b0) $display("FAIL b2b_valid_after: got %b expected 0", so_valid); else passes++;
    endtask

    task automatic test_stall();
        load_valid = 1'b1; load_data = 4'b1001; mode = 1'b0; shift_en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        checks++; if (SO !== 1'b1) $display("FAIL stall_bit0: got %b expected 1", SO); else passes++;
        @(negedge clk);
        checks++; if (SO !== 1'b0) $display("FAIL stall_bit1: got %b expected 0", SO); else passes++;
        shift_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (SO !== 1'b0) $display("FAIL stall_so[%0d]: got %b expected 0", i, SO); else passes++;
            checks++; if (so_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b expected 1", i, so_valid); else passes++;
            checks++; if (so_last !== 1'b0) $display("FAIL stall_last[%0d]: got %b expected 0", i, so_last); else passes++;
            checks++; if (SR !== 4'b0010) $display("FAIL stall_sr[%0d]: got %b expected 0010", i, SR); else passes++;
        end
        shift_en = 1'b1;
        @(negedge clk);
        checks++; if (SO !== 1'b0) $display("FAIL stall_bit2: got %b expected 0", SO); else passes++;
        checks++; if (SR !== 4'b0100) $display("FAIL stall_sr_bit2: got %b expected 0100", SR); else passes++;
        @(negedge clk);
        checks++; if (SO !== 1'b1) $display("FAIL stall_bit3: got %b expected 1", SO); else passes++;
        checks++; if (so_last !== 1'b1) $display("FAIL stall_last_bit3: got %b expected 1", so_last); else passes++;
        @(negedge clk);
        checks++; if (so_valid !== 1'b0) $display("FAIL stall_valid_after: got %b expected 0", so_valid); else passes++;
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_bits;
        exp_bits = 4'b1010;
        load_valid = 1'b1; load_data = 4'b1111; mode = 1'b0; shift_en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (so_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b expected 1", so_valid); else passes++;
        // Assert reset between edges; outputs must clear without a clock.
        #2 rst = 1'b0;
        #1;
        checks++; if (SO !== 1'b0) $display("FAIL arst_so: got %b expected 0", SO); else passes++;
        checks++; if (so_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", so_valid); else passes++;
        checks++; if (SR !== 4'b0000) $display("FAIL arst_sr: got %b expected 0000", SR); else passes++;
        checks++; if (load_ready !== 1'b1) $display("FAIL arst_ready: got %b expected 1", load_ready); else passes++;
        @(negedge clk);
        rst = 1'b1; load_valid = 1'b1; load_data = 4'b1010; mode = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        checks++; if (SR !== 4'b1010) $display("FAIL arst_new_sr: got %b expected 1010", SR); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (SO !== exp_bits[3-i]) $display("FAIL arst_so[%0d]: got %b expected %b", i, SO, exp_bits[3-i]); else passes++;
            checks++; if (so_valid !== 1'b1) $display("FAIL arst_new_valid[%0d]: got %b expected 1", i, so_valid); else passes++;
            @(negedge clk);
        end
        checks++; if (so_valid !== 1'b0) $display("FAIL arst_valid_after: got %b expected 0", so_valid); else passes++;
    endtask

    task automatic test_mode_change();
        logic [7:0] exp_bits;
        exp_bits = 8'b0011_0101;
        load_valid = 1'b1; load_data = 4'b0011; mode = 1'b0; shift_en = 1'b1;
        @(negedge clk);
        load_data = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            checks++; if (SO !== exp_bits[7-i]) $display("FAIL mode_so[%0d]: got %b expected %b", i, SO, exp_bits[7-i]); else passes++;
            if (i < 4) begin
                checks++; if (load_ready !== (i == 3)) $display("FAIL mode_ready[%0d]: got %b expected %b", i, load_ready, (i == 3)); else passes++;
            end
            // Toggle mode every cycle; the value present at i == 3 (0) is the one captured.
            mode = (i % 2 == 0);
            if (i == 4) load_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (so_valid !== 1'b0) $display("FAIL mode_valid_after: got %b expected 0", so_valid); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_mode_change();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
